// File: rtl/blink_led_array_if.sv
// Configuration and LED bus for the multi-channel blinker.
// The master side programs the channels and sets their run enables.
// The slave side (the blinker itself) drives the per-channel status lines.
interface blink_led_array_if #(
    parameter int N_CH = 4,
    parameter int TW   = 8,
    parameter int CW   = 8
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0] enable;
    logic            cfg_we;
    logic [CHW-1:0]  cfg_ch;
    logic [TW-1:0]   cfg_on;
    logic [TW-1:0]   cfg_off;
    logic [CW-1:0]   cfg_burst;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] done;
    logic [N_CH-1:0] busy;

    modport master (
        output enable, cfg_we, cfg_ch, cfg_on, cfg_off, cfg_burst,
        input  led, done, busy
    );

    modport slave (
        input  enable, cfg_we, cfg_ch, cfg_on, cfg_off, cfg_burst,
        output led, done, busy
    );
endinterface

// File: rtl/blink_led_array.sv
// N_CH independent Moore blink engines sharing one configuration port.
// Each channel blinks with programmable on/off times, either forever
// or for a programmed number of blinks, after which it parks in DONE.
module blink_led_array #(
    parameter int N_CH    = 4,
    parameter int TW      = 8,
    parameter int CW      = 8,
    parameter int DEF_ON  = 4,
    parameter int DEF_OFF = 8
) (
    input logic                clk,
    input logic                rst_n,
    blink_led_array_if.slave   bus
);
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

    state_t          state_q  [N_CH];
    state_t          state_nx [N_CH];
    logic [TW-1:0]   t_q      [N_CH];
    logic [CW-1:0]   cnt_q    [N_CH];
    logic [TW-1:0]   on_q     [N_CH];
    logic [TW-1:0]   off_q    [N_CH];
    logic [CW-1:0]   burst_q  [N_CH];
    logic [N_CH-1:0] on_end;
    logic [N_CH-1:0] off_end;
    logic [N_CH-1:0] burst_end;
    logic [N_CH-1:0] led_q;
    logic [N_CH-1:0] done_q;
    logic [N_CH-1:0] busy_q;

    // Per-channel configuration registers; out-of-range channel numbers match no slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                on_q[i]    <= TW'(DEF_ON);
                off_q[i]   <= TW'(DEF_OFF);
                burst_q[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.cfg_ch == CHW'(i)) begin
                    on_q[i]    <= bus.cfg_on;
                    off_q[i]   <= bus.cfg_off;
                    burst_q[i] <= bus.cfg_burst;
                end
            end
        end
    end

    // Phase-end and burst-end conditions; a zero duration behaves like one cycle.
    always_comb begin
        on_end    = '0;
        off_end   = '0;
        burst_end = '0;
        for (int i = 0; i < N_CH; i++) begin
            on_end[i]    = (on_q[i] == '0)  ? 1'b1 : (t_q[i] >= (on_q[i]  - TW'(1)));
            off_end[i]   = (off_q[i] == '0) ? 1'b1 : (t_q[i] >= (off_q[i] - TW'(1)));
            burst_end[i] = (burst_q[i] != '0) && (cnt_q[i] >= burst_q[i]);
        end
    end

    // Next-state decode; a low enable overrides any timer event.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_nx[i] = state_q[i];
            case (state_q[i])
                IDLE: if (bus.enable[i]) state_nx[i] = ON;
                ON: begin
                    if (!bus.enable[i])  state_nx[i] = IDLE;
                    else if (on_end[i])  state_nx[i] = OFF;
                end
                OFF: begin
                    if (!bus.enable[i])  state_nx[i] = IDLE;
                    else if (off_end[i]) state_nx[i] = burst_end[i] ? DONE : ON;
                end
                DONE: if (!bus.enable[i]) state_nx[i] = IDLE;
                default: state_nx[i] = IDLE;
            endcase
        end
    end

    // State, timer, blink counter and registered Moore outputs for every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= IDLE;
                t_q[i]     <= '0;
                cnt_q[i]   <= '0;
            end
            led_q  <= '0;
            done_q <= '0;
            busy_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_nx[i];
                if (state_nx[i] != state_q[i])
                    t_q[i] <= '0;
                else if (t_q[i] != {TW{1'b1}})
                    t_q[i] <= t_q[i] + TW'(1);
                if (state_q[i] == IDLE)
                    cnt_q[i] <= '0;
                else if (state_q[i] == ON && state_nx[i] == OFF && cnt_q[i] != {CW{1'b1}})
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                led_q[i]  <= (state_nx[i] == ON);
                done_q[i] <= (state_nx[i] == DONE);
                busy_q[i] <= (state_nx[i] == ON) || (state_nx[i] == OFF);
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_blink_led_array.sv
// Directed bench for blink_led_array: expectations are queued before each
// clock edge and compared against the channel outputs just after it.
module tb_blink_led_array;
    localparam int N_CH = 5;
    localparam int TW   = 8;
    localparam int CW   = 8;

    typedef struct {
        string tag;
        int    ch;
        logic  led;
        logic  done;
        logic  busy;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    blink_led_array_if #(.N_CH(N_CH), .TW(TW), .CW(CW)) bus ();

    blink_led_array #(
        .N_CH(N_CH), .TW(TW), .CW(CW), .DEF_ON(4), .DEF_OFF(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareBit(input string tag, input string sig, input logic obs, input logic want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s %s observed=%b expected=%b", tag, sig, obs, want);
        end
    endtask

    task automatic expectCh(input string tag, input int ch, input logic led, input logic done, input logic busy);
        exp_t e;
        e.tag  = tag;
        e.ch   = ch;
        e.led  = led;
        e.done = done;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    task automatic expectAllIdle(input string tag);
        for (int c = 0; c < N_CH; c++) expectCh($sformatf("%s ch%0d", tag, c), c, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compareBit(e.tag, "led",  bus.led[e.ch],  e.led);
            compareBit(e.tag, "done", bus.done[e.ch], e.done);
            compareBit(e.tag, "busy", bus.busy[e.ch], e.busy);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic we, input int ch, input int on, input int off, input int burst);
        bus.cfg_we    = we;
        bus.cfg_ch    = 3'(ch);
        bus.cfg_on    = TW'(on);
        bus.cfg_off   = TW'(off);
        bus.cfg_burst = CW'(burst);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.enable  = '1;
        applyStimulus(1'b0, 0, 0, 0, 0);

        // Reset held with every channel enabled
        repeat (3) begin
            expectAllIdle("reset");
            tick();
        end
        rst_n = 1'b1;

        // Default 4 on / 8 off blinking, five periods
        for (int k = 1; k <= 60; k++) begin
            expectCh($sformatf("default k=%0d", k), 0, ((k - 1) % 12) < 4, 1'b0, 1'b1);
            expectCh($sformatf("default4 k=%0d", k), 4, ((k - 1) % 12) < 4, 1'b0, 1'b1);
            tick();
        end

        // Burst of three 2/3 blinks on ch1
        bus.enable = '0;
        expectAllIdle("stop");
        tick();
        applyStimulus(1'b1, 1, 2, 3, 3);
        expectCh("cfg1", 1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 0);
        bus.enable[1] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 15)
                expectCh($sformatf("burst k=%0d", k), 1, ((k - 1) % 5) < 2, 1'b0, 1'b1);
            else
                expectCh($sformatf("burst k=%0d", k), 1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        bus.enable[1] = 1'b0;
        expectCh("burst drop", 1, 1'b0, 1'b0, 1'b0);
        tick();

        // Disable mid-ON on ch0, then re-enable for a full phase
        applyStimulus(1'b1, 0, 10, 8, 0);
        expectCh("cfg0", 0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 0);
        bus.enable[0] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            expectCh($sformatf("on10 k=%0d", k), 0, 1'b1, 1'b0, 1'b1);
            tick();
        end
        bus.enable[0] = 1'b0;
        expectCh("midon drop", 0, 1'b0, 1'b0, 1'b0);
        tick();
        bus.enable[0] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            expectCh($sformatf("reon k=%0d", k), 0, k <= 10, 1'b0, 1'b1);
            tick();
        end
        bus.enable[0] = 1'b0;
        expectCh("reon stop", 0, 1'b0, 1'b0, 1'b0);
        tick();

        // Shortening ON mid-phase on ch2, then zero durations toggle every cycle
        applyStimulus(1'b1, 2, 20, 8, 0);
        expectCh("cfg2", 2, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 0);
        bus.enable[2] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 8)      applyStimulus(1'b1, 2, 3, 8, 0);
            else if (k == 9) applyStimulus(1'b1, 2, 0, 0, 0);
            else             applyStimulus(1'b0, 0, 0, 0, 0);
            expectCh($sformatf("midwr k=%0d", k), 2,
                     (k <= 8) ? 1'b1 : ((k == 9) ? 1'b0 : ((k % 2) == 0)), 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 0, 0, 0, 0);
        bus.enable[2] = 1'b0;
        expectCh("midwr stop", 2, 1'b0, 1'b0, 1'b0);
        tick();

        // Out-of-range and neighbour writes while ch0 and ch2 run
        applyStimulus(1'b1, 0, 3, 2, 0);
        tick();
        applyStimulus(1'b1, 2, 2, 2, 0);
        tick();
        applyStimulus(1'b0, 0, 0, 0, 0);
        bus.enable = 5'b00101;
        for (int k = 1; k <= 20; k++) begin
            case (k)
                3:       applyStimulus(1'b1, 5, 1, 1, 1);
                6:       applyStimulus(1'b1, 6, 1, 1, 1);
                9:       applyStimulus(1'b1, 7, 1, 1, 1);
                12:      applyStimulus(1'b1, 3, 1, 1, 1);
                default: applyStimulus(1'b0, 0, 0, 0, 0);
            endcase
            expectCh($sformatf("iso0 k=%0d", k), 0, ((k - 1) % 5) < 3, 1'b0, 1'b1);
            expectCh($sformatf("iso2 k=%0d", k), 2, ((k - 1) % 4) < 2, 1'b0, 1'b1);
            expectCh($sformatf("iso1 k=%0d", k), 1, 1'b0, 1'b0, 1'b0);
            expectCh($sformatf("iso3 k=%0d", k), 3, 1'b0, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 0, 0, 0, 0);

        // Reset mid-burst on every channel restores defaults
        bus.enable = '0;
        expectAllIdle("preburst");
        tick();
        for (int c = 0; c < N_CH; c++) begin
            applyStimulus(1'b1, c, 2, 2, 1);
            tick();
        end
        applyStimulus(1'b0, 0, 0, 0, 0);
        bus.enable = '1;
        for (int k = 1; k <= 3; k++) begin
            for (int c = 0; c < N_CH; c++)
                expectCh($sformatf("allrun k=%0d ch%0d", k, c), c, k <= 2, 1'b0, 1'b1);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < N_CH; c++) begin
            compareBit($sformatf("async ch%0d", c), "led",  bus.led[c],  1'b0);
            compareBit($sformatf("async ch%0d", c), "busy", bus.busy[c], 1'b0);
        end
        repeat (2) begin
            expectAllIdle("inreset");
            tick();
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            for (int c = 0; c < N_CH; c++)
                expectCh($sformatf("restored k=%0d ch%0d", k, c), c, ((k - 1) % 12) < 4, 1'b0, 1'b1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
